// File: rtl/queue_param_fifo_pkg.sv
// ---------------------------------------------------------------------------
// queue_pkg
//   Shared definitions for the parametrised FIFO queue: default geometry,
//   a constant-evaluable ceil(log2) helper and the pointer advance with
//   wrap used for queues whose depth is not a power of two.
// ---------------------------------------------------------------------------
package queue_pkg;

  localparam int DEFAULT_WIDTH = 4;
  localparam int DEFAULT_DEPTH = 8;

  // Number of bits needed to encode values 0..value-1 (0 for value <= 1).
  function automatic int clog2(input int value);
    int result;
    int remain;
    result = 0;
    remain = value - 1;
    while (remain > 0) begin
      result = result + 1;
      remain = remain >> 1;
    end
    return result;
  endfunction

  // Pointers wrap explicitly at depth-1 so any depth >= 2 works.
  function automatic int next_ptr(input int ptr, input int depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/queue_param_fifo_if.sv
// ---------------------------------------------------------------------------
// queue_param_fifo_if
//   Producer/consumer side of the FIFO queue.
//   master : flush, push, pop, Din driven by the user of the queue
//   slave  : the queue itself; drives Dout, Dout_vld, count, status flags
//            and the overflow/underflow pulses
// ---------------------------------------------------------------------------
interface queue_param_fifo_if
  import queue_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH
) ();

  localparam int CW = clog2(DEPTH + 1);

  logic             flush;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] Din;
  logic [WIDTH-1:0] Dout;
  logic             Dout_vld;
  logic [CW-1:0]    count;
  logic             isFull;
  logic             isEmpty;
  logic             isAlmostFull;
  logic             isAlmostEmpty;
  logic             overflow;
  logic             underflow;

  modport master (
    output flush, push, pop, Din,
    input  Dout, Dout_vld, count, isFull, isEmpty,
           isAlmostFull, isAlmostEmpty, overflow, underflow
  );

  modport slave (
    input  flush, push, pop, Din,
    output Dout, Dout_vld, count, isFull, isEmpty,
           isAlmostFull, isAlmostEmpty, overflow, underflow
  );

endinterface

// File: rtl/queue_param_fifo_ram.sv
// ---------------------------------------------------------------------------
// queue_ram
//   Simple dual-port storage, WIDTH x DEPTH, no reset.
//   clk     : clock
//   wr_en   : write strobe, wr_data stored at wr_addr on the rising edge
//   wr_addr : write address
//   wr_data : write data
//   rd_en   : read strobe, rd_data loaded from rd_addr on the rising edge
//   rd_addr : read address
//   rd_data : registered read data, holds while rd_en is low
// ---------------------------------------------------------------------------
module queue_ram #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Read port; a same-edge write to rd_addr returns the old contents.
  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/queue_param_fifo.sv
// ---------------------------------------------------------------------------
// queue_param_fifo
//   Parametrised single-clock FIFO queue with independent push/pop strobes,
//   occupancy count, almost-full/almost-empty thresholds, overflow/underflow
//   pulses and synchronous flush.
//   clk : clock, rising edge
//   rst : synchronous active-high reset
//   bus : queue_param_fifo_if.slave (flush/push/pop/Din in; Dout, Dout_vld,
//         count, isFull, isEmpty, isAlmostFull, isAlmostEmpty, overflow,
//         underflow out)
// ---------------------------------------------------------------------------
module queue_param_fifo
  import queue_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int DEPTH    = DEFAULT_DEPTH,
  parameter int AF_LEVEL = 6,
  parameter int AE_LEVEL = 2
) (
  input logic                clk,
  input logic                rst,
  queue_param_fifo_if.slave  bus
);

  localparam int PW = clog2(DEPTH);
  localparam int CW = clog2(DEPTH + 1);

  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             dout_vld;
  logic             overflow;
  logic             underflow;
  logic             dout_loaded;
  logic [WIDTH-1:0] rd_data;
  logic             active;
  logic             pop_ok;
  logic             push_ok;

  // Reset and flush both suppress any push/pop in that cycle. A full queue
  // still accepts a push when a pop frees a slot on the same edge.
  always_comb begin
    active  = !rst && !bus.flush;
    pop_ok  = active && bus.pop && (count != '0);
    push_ok = active && bus.push && ((count != CW'(DEPTH)) || pop_ok);
  end

  queue_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (PW)
  ) u_ram (
    .clk     (clk),
    .wr_en   (push_ok),
    .wr_addr (wr_ptr),
    .wr_data (bus.Din),
    .rd_en   (pop_ok),
    .rd_addr (rd_ptr),
    .rd_data (rd_data)
  );

  // Pointers, occupancy, output-valid and the error pulses. dout_loaded
  // marks that the RAM output register has captured real data; until then
  // Dout reads as zero, which gives a reset value without resetting the RAM.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      dout_vld    <= 1'b0;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
      dout_loaded <= 1'b0;
    end else if (bus.flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      dout_vld  <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= PW'(next_ptr(int'(wr_ptr), DEPTH));
      if (pop_ok) begin
        rd_ptr      <= PW'(next_ptr(int'(rd_ptr), DEPTH));
        dout_loaded <= 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      dout_vld  <= pop_ok;
      overflow  <= bus.push && !push_ok;
      underflow <= bus.pop && !pop_ok;
    end
  end

  assign bus.Dout          = dout_loaded ? rd_data : '0;
  assign bus.Dout_vld      = dout_vld;
  assign bus.count         = count;
  assign bus.isFull        = (count == CW'(DEPTH));
  assign bus.isEmpty       = (count == '0);
  assign bus.isAlmostFull  = (count >= CW'(AF_LEVEL));
  assign bus.isAlmostEmpty = (count <= CW'(AE_LEVEL));
  assign bus.overflow      = overflow;
  assign bus.underflow     = underflow;

endmodule

// File: tb/tb_queue_param_fifo.sv
// ---------------------------------------------------------------------------
// tb_queue_param_fifo
//   Scoreboard bench for queue_param_fifo (WIDTH=4, DEPTH=8, AF=6, AE=2).
//   Each stimulus cycle pushes the expected post-edge state into a queue; a
//   separate monitor pops and compares after every edge. Directed checks
//   with hand-computed values cover the key boundary points.
// ---------------------------------------------------------------------------
module tb_queue_param_fifo;

  localparam int WIDTH = 4;
  localparam int DEPTH = 8;
  localparam int AF    = 6;
  localparam int AE    = 2;

  typedef struct {
    int count;
    int dout;
    bit vld;
    bit ovf;
    bit unf;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  exp_t expq[$];
  int   model_q[$];
  int   model_dout = 0;
  int   checks = 0;
  int   errors = 0;
  int   max_count;

  always #5 clk = ~clk;

  queue_param_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus_if ();

  queue_param_fifo #(
    .WIDTH    (WIDTH),
    .DEPTH    (DEPTH),
    .AF_LEVEL (AF),
    .AE_LEVEL (AE)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Drive one cycle at the falling edge, record the expected result, and
  // return 2 time units after the rising edge so callers can sample.
  task automatic applyStimulus(input bit r, input bit f, input bit ps, input bit pp, input int din);
    exp_t e;
    bit   popok;
    bit   pushok;
    @(negedge clk);
    rst         = r;
    bus_if.flush = f;
    bus_if.push = ps;
    bus_if.pop  = pp;
    bus_if.Din  = WIDTH'(din);
    e.vld = 1'b0;
    e.ovf = 1'b0;
    e.unf = 1'b0;
    if (r) begin
      model_q.delete();
      model_dout = 0;
    end else if (f) begin
      model_q.delete();
    end else begin
      popok  = pp && (model_q.size() != 0);
      pushok = ps && ((model_q.size() != DEPTH) || popok);
      if (popok) model_dout = model_q.pop_front();
      if (pushok) model_q.push_back(din & 15);
      e.vld = popok;
      e.ovf = ps && !pushok;
      e.unf = pp && !popok;
    end
    e.count = model_q.size();
    e.dout  = model_dout;
    expq.push_back(e);
    @(posedge clk);
    #2;
  endtask

  // Monitor: compare every post-edge state against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        checkOutput("sb_count",    int'(bus_if.count),         e.count);
        checkOutput("sb_dout",     int'(bus_if.Dout),          e.dout);
        checkOutput("sb_dout_vld", int'(bus_if.Dout_vld),      int'(e.vld));
        checkOutput("sb_overflow", int'(bus_if.overflow),      int'(e.ovf));
        checkOutput("sb_underflow",int'(bus_if.underflow),     int'(e.unf));
        checkOutput("sb_full",     int'(bus_if.isFull),        int'(e.count == DEPTH));
        checkOutput("sb_empty",    int'(bus_if.isEmpty),       int'(e.count == 0));
        checkOutput("sb_afull",    int'(bus_if.isAlmostFull),  int'(e.count >= AF));
        checkOutput("sb_aempty",   int'(bus_if.isAlmostEmpty), int'(e.count <= AE));
      end
    end
  end

  initial begin
    int w;
    rst          = 1'b1;
    bus_if.flush = 1'b0;
    bus_if.push  = 1'b0;
    bus_if.pop   = 1'b0;
    bus_if.Din   = '0;

    // Reset held 3 cycles with push asserted.
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 1, 0, 5);
    checkOutput("rst_count",    int'(bus_if.count),         0);
    checkOutput("rst_empty",    int'(bus_if.isEmpty),       1);
    checkOutput("rst_dout",     int'(bus_if.Dout),          0);
    checkOutput("rst_vld",      int'(bus_if.Dout_vld),      0);
    checkOutput("rst_overflow", int'(bus_if.overflow),      0);
    checkOutput("rst_aempty",   int'(bus_if.isAlmostEmpty), 1);

    // Fill with 1..8, then one push too many.
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(0, 0, 1, 0, i);
      checkOutput("fill_count", int'(bus_if.count),        i);
      checkOutput("fill_afull", int'(bus_if.isAlmostFull), int'(i >= 6));
    end
    checkOutput("fill_full", int'(bus_if.isFull), 1);
    applyStimulus(0, 0, 1, 0, 9);
    checkOutput("ovf_pulse", int'(bus_if.overflow), 1);
    checkOutput("ovf_count", int'(bus_if.count),    8);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("ovf_one_cycle", int'(bus_if.overflow), 0);

    // Drain 8 words plus one extra pop.
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(0, 0, 0, 1, 0);
      checkOutput("drain_dout",   int'(bus_if.Dout),          i);
      checkOutput("drain_vld",    int'(bus_if.Dout_vld),      1);
      checkOutput("drain_aempty", int'(bus_if.isAlmostEmpty), int'((8 - i) <= 2));
    end
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("unf_pulse", int'(bus_if.underflow), 1);
    checkOutput("unf_dout",  int'(bus_if.Dout),      8);
    checkOutput("unf_vld",   int'(bus_if.Dout_vld),  0);

    // Wrap: 5 in, 5 out, then 12 more words one at a time.
    max_count = 0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 0, 1, 0, 3 + i);
      if (int'(bus_if.count) > max_count) max_count = int'(bus_if.count);
    end
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 0, 0, 1, 0);
      checkOutput("wrap_dout_a", int'(bus_if.Dout), 3 + i);
    end
    for (int i = 0; i < 12; i++) begin
      w = (i * 5 + 1) & 15;
      applyStimulus(0, 0, 1, 0, w);
      if (int'(bus_if.count) > max_count) max_count = int'(bus_if.count);
      applyStimulus(0, 0, 0, 1, 0);
      checkOutput("wrap_dout_b", int'(bus_if.Dout), w);
    end
    checkOutput("wrap_max_count", max_count, 5);

    // Simultaneous push+pop at full, then at empty.
    for (int i = 8; i < 16; i++) applyStimulus(0, 0, 1, 0, i);
    applyStimulus(0, 0, 1, 1, 10);
    checkOutput("full_pp_count", int'(bus_if.count),    8);
    checkOutput("full_pp_ovf",   int'(bus_if.overflow), 0);
    checkOutput("full_pp_dout",  int'(bus_if.Dout),     8);
    for (int i = 0; i < 8; i++) applyStimulus(0, 0, 0, 1, 0);
    checkOutput("full_pp_last", int'(bus_if.Dout), 10);
    applyStimulus(0, 0, 1, 1, 6);
    checkOutput("empty_pp_count", int'(bus_if.count),     1);
    checkOutput("empty_pp_unf",   int'(bus_if.underflow), 1);
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("empty_pp_dout", int'(bus_if.Dout), 6);

    // Flush mid-stream with push asserted; Dout must hold.
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 1, 0, 1 + i);
    checkOutput("pre_flush_count", int'(bus_if.count), 5);
    applyStimulus(0, 1, 1, 0, 3);
    checkOutput("flush_count", int'(bus_if.count),   0);
    checkOutput("flush_empty", int'(bus_if.isEmpty), 1);
    checkOutput("flush_dout",  int'(bus_if.Dout),    6);
    applyStimulus(0, 0, 1, 0, 12);
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("post_flush_dout", int'(bus_if.Dout), 12);
    applyStimulus(0, 0, 0, 0, 0);

    #1;
    checkOutput("sb_drained", expq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
